// File: rtl/frame_serializer.sv
// frame_serializer: double-buffered parallel-to-serial shifter with ready/valid load,
// per-frame bit order and programmable frame length.
module frame_serializer #(
    parameter int bus_width = 8,
    parameter int cnt_width = $clog2(bus_width + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 data_valid,
    output logic                 data_ready,
    input  logic [bus_width-1:0] p_data,
    input  logic                 msb_first,
    input  logic [cnt_width-1:0] frame_len,
    output logic                 s_data,
    output logic                 busy,
    output logic                 frame_done
);
    localparam logic [cnt_width-1:0] full_len = cnt_width'(bus_width);

    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state, state_nxt;

    logic                 hold_full, hold_msb;
    logic [bus_width-1:0] hold_data;
    logic [cnt_width-1:0] hold_len;
    logic [bus_width-1:0] shreg, aligned;
    logic                 sh_msb;
    logic [cnt_width-1:0] cnt, len_legal;
    logic                 accept, load, step, last;

    assign data_ready = !hold_full;
    assign busy       = state == SHIFT;
    assign accept     = data_valid && !hold_full;
    assign len_legal  = (frame_len == '0 || frame_len > full_len) ? full_len : frame_len;
    assign step       = state == SHIFT && enable;
    assign last       = step && cnt == cnt_width'(1);
    assign load       = hold_full && (state == IDLE || last);
    // MSB frames are left-aligned so the first bit always sits at the top of the shifter
    assign aligned    = hold_msb ? hold_data << (full_len - hold_len) : hold_data;

    always_comb begin
        state_nxt = state;
        if (load) state_nxt = SHIFT;
        else if (last) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_full  <= 1'b0;
            hold_msb   <= 1'b0;
            hold_data  <= '0;
            hold_len   <= '0;
            shreg      <= '0;
            sh_msb     <= 1'b0;
            cnt        <= '0;
            s_data     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (accept) begin
                hold_data <= p_data;
                hold_msb  <= msb_first;
                hold_len  <= len_legal;
            end
            if (load) hold_full <= 1'b0;
            else if (accept) hold_full <= 1'b1;
            frame_done <= last;
            if (step) s_data <= sh_msb ? shreg[bus_width-1] : shreg[0];
            if (load) begin
                shreg  <= aligned;
                sh_msb <= hold_msb;
                cnt    <= hold_len;
            end else if (step) begin
                shreg <= sh_msb ? shreg << 1 : shreg >> 1;
                cnt   <= cnt - cnt_width'(1);
            end
        end
    end
endmodule

// File: tb/tb_frame_serializer.sv
// tb_frame_serializer: directed and random stimulus against a frame-level bit-queue model.
module tb_frame_serializer;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0, data_valid = 1'b0, msb_first = 1'b0;
    logic [7:0] p_data = '0;
    logic [3:0] frame_len = '0;
    logic       data_ready, s_data, busy, frame_done;

    frame_serializer #(.bus_width(8)) dut (
        .clk(clk), .rst(rst), .enable(enable), .data_valid(data_valid),
        .data_ready(data_ready), .p_data(p_data), .msb_first(msb_first),
        .frame_len(frame_len), .s_data(s_data), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int passed = 0, total = 0;
    bit q_bits[$];
    bit q_last[$];
    bit m_hold_full, m_active, m_done, m_sdata;
    logic [15:0] seq;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_clear();
        q_bits.delete();
        q_last.delete();
        m_hold_full = 0;
        m_active    = 0;
        m_done      = 0;
        m_sdata     = 0;
    endtask

    // one clock with the given inputs; the model advances by frame-level rules, then all outputs are compared
    task automatic step(input logic en, input logic vld, input logic [7:0] d,
                        input logic msb, input logic [3:0] len);
        bit acc;
        int l;
        enable = en; data_valid = vld; p_data = d; msb_first = msb; frame_len = len;
        acc = vld && !m_hold_full;
        @(posedge clk);
        #1;
        m_done = 0;
        if (!m_active) begin
            if (m_hold_full) begin
                m_active    = 1;
                m_hold_full = 0;
            end
        end else if (en && q_bits.size() != 0) begin
            m_sdata = q_bits.pop_front();
            if (q_last.pop_front()) begin
                m_done = 1;
                if (m_hold_full) m_hold_full = 0;
                else m_active = 0;
            end
        end
        if (acc) begin
            l = (len == 0 || len > 8) ? 8 : int'(len);
            for (int i = 0; i < l; i++) begin
                q_bits.push_back(msb ? d[l-1-i] : d[i]);
                q_last.push_back(i == l - 1);
            end
            m_hold_full = 1;
        end
        enable = 0; data_valid = 0;
        check("data_ready", 32'(data_ready), 32'(!m_hold_full));
        check("busy", 32'(busy), 32'(m_active));
        check("frame_done", 32'(frame_done), 32'(m_done));
        check("s_data", 32'(s_data), 32'(m_sdata));
    endtask

    task automatic collect(input int n);
        for (int i = 0; i < n; i++) begin
            step(1, 0, 8'h00, 0, 4'd0);
            seq = {seq[14:0], s_data};
        end
    endtask

    task automatic drain();
        int k = 0;
        while ((m_active || m_hold_full) && k < 100) begin
            step(1, 0, 8'h00, 0, 4'd0);
            k++;
        end
        check("drain_timeout", 32'(k < 100), 32'd1);
    endtask

    initial begin
        model_clear();
        #2;
        check("rst_s_data", 32'(s_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_data_ready", 32'(data_ready), 32'd1);
        #10 rst = 1'b1;

        // MSB 0xA5, full length; enable held high through the load edge to show it is ignored
        step(1, 1, 8'hA5, 1, 4'd8);
        step(1, 0, 8'h00, 0, 4'd0);
        collect(8);
        check("msb_a5", 32'(seq[7:0]), 32'hA5);
        step(1, 0, 8'h00, 0, 4'd0);

        // LSB 0x1D
        step(0, 1, 8'h1D, 0, 4'd8);
        step(0, 0, 8'h00, 0, 4'd0);
        collect(8);
        check("lsb_1d", 32'(seq[7:0]), 32'hB8);
        step(1, 0, 8'h00, 0, 4'd0);

        // short frame: only the low nibble goes out
        step(0, 1, 8'hFB, 1, 4'd4);
        step(0, 0, 8'h00, 0, 4'd0);
        collect(4);
        check("len4_fb", 32'(seq[3:0]), 32'hB);
        collect(3);

        // zero length means full width
        step(0, 1, 8'h1D, 1, 4'd0);
        step(0, 0, 8'h00, 0, 4'd0);
        collect(8);
        check("len0_1d", 32'(seq[7:0]), 32'h1D);
        step(1, 0, 8'h00, 0, 4'd0);

        // back-to-back: second frame queued on the first shift edge
        step(0, 1, 8'h0F, 1, 4'd8);
        step(0, 0, 8'h00, 0, 4'd0);
        for (int i = 0; i < 16; i++) begin
            step(1, i == 0, 8'hF0, 1, 4'd8);
            seq = {seq[14:0], s_data};
        end
        check("b2b_stream", 32'(seq), 32'h0FF0);
        step(1, 0, 8'h00, 0, 4'd0);

        // sparse enable; third frame attempted repeatedly while the hold buffer is full
        step(0, 1, 8'h96, 1, 4'd8);
        step(0, 0, 8'h00, 0, 4'd0);
        step(0, 1, 8'h3C, 0, 4'd6);
        for (int i = 0; i < 48; i++) step(i % 3 == 2, i < 10, 8'hFF, 1, 4'd8);
        drain();

        // reset mid-frame with a frame also queued
        step(0, 1, 8'h5A, 1, 4'd8);
        step(0, 0, 8'h00, 0, 4'd0);
        step(1, 1, 8'hC3, 0, 4'd8);
        step(1, 0, 8'h00, 0, 4'd0);
        #2 rst = 1'b0;
        #1;
        model_clear();
        check("mid_rst_s_data", 32'(s_data), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_frame_done", 32'(frame_done), 32'd0);
        check("mid_rst_data_ready", 32'(data_ready), 32'd1);
        #3 rst = 1'b1;
        for (int i = 0; i < 4; i++) step(1, 0, 8'h00, 0, 4'd0);

        // random traffic, including illegal lengths above the bus width
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 1), $urandom_range(0, 2) == 0, 8'($urandom),
                 $urandom_range(0, 1), 4'($urandom_range(0, 15)));
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
